// File: rtl/pulse_bram_reader_pkg.sv
// Shared definitions for the pulse-table reader: table geometry, the reader
// state encoding and the word-to-byte address helper.
package pulse_pkg;

    localparam int unsigned PULSE_DEPTH = 13;
    localparam int unsigned WORD_BYTES  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_OUT,
        ST_CLR,
        ST_DONE
    } reader_state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + idx * WORD_BYTES;
    endfunction

endpackage

// File: rtl/pulse_bram_reader_if.sv
// Single-port BRAM bus shared between the pulse-table reader (master) and
// the memory or port arbiter behind it (slave).
interface pulse_bram_if;

    logic [31:0] bram_addr;
    logic [31:0] bram_data_in;
    logic        bram_we;
    logic        bram_ena;
    logic [31:0] bram_data_out;

    modport master (
        output bram_addr,
        output bram_data_in,
        output bram_we,
        output bram_ena,
        input  bram_data_out
    );

    modport slave (
        input  bram_addr,
        input  bram_data_in,
        input  bram_we,
        input  bram_ena,
        output bram_data_out
    );

endinterface

// File: rtl/pulse_bram_reader.sv
// Streams one frame of 32-bit pulse samples out of a single-port BRAM,
// optionally zeroing each word once the consumer has accepted it.
module pulse_bram_reader
    import pulse_pkg::*;
#(
    parameter int unsigned DEPTH         = PULSE_DEPTH,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter bit          CLEAR_ON_READ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_data_in,
    output logic        bram_we,
    output logic        bram_ena,
    input  logic [31:0] bram_data_out,
    output logic [31:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    reader_state_t    r_state;
    logic [IDX_W-1:0] r_index;
    logic [31:0]      r_addr;
    logic             r_we;
    logic             r_ena;
    logic [31:0]      r_sample_data;
    logic             r_sample_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_handshake;
    logic [IDX_W-1:0] w_next_index;
    logic [31:0]      w_cur_addr;
    logic [31:0]      w_next_addr;

    assign w_handshake  = r_sample_valid && sample_ready;
    assign w_next_index = r_index + 1'b1;
    assign w_cur_addr   = word_addr(BASE_ADDR, 32'(r_index));
    assign w_next_addr  = word_addr(BASE_ADDR, 32'(w_next_index));

    // Outputs are updated on the edge that enters a state, so bram_ena is
    // high exactly while in RD_REQ, RD_WAIT and the CLR write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_index        <= '0;
            r_addr         <= '0;
            r_we           <= 1'b0;
            r_ena          <= 1'b0;
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else if (abort && (r_state != ST_IDLE)) begin
            // Abort beats a same-cycle handshake, so an unaccepted word is never cleared.
            r_state        <= ST_IDLE;
            r_index        <= '0;
            r_we           <= 1'b0;
            r_ena          <= 1'b0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_index <= '0;
                        r_addr  <= word_addr(BASE_ADDR, 32'd0);
                        r_ena   <= 1'b1;
                        r_we    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_ena   <= 1'b0;
                    r_state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    r_sample_data  <= bram_data_out;
                    r_sample_valid <= 1'b1;
                    r_state        <= ST_OUT;
                end
                ST_OUT: begin
                    if (w_handshake) begin
                        r_sample_valid <= 1'b0;
                        r_addr         <= w_cur_addr;
                        r_we           <= CLEAR_ON_READ;
                        r_ena          <= CLEAR_ON_READ;
                        r_state        <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    r_we <= 1'b0;
                    if (r_index == LAST_IDX) begin
                        r_ena   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        // Next read is issued back-to-back with the clear write.
                        r_index <= w_next_index;
                        r_addr  <= w_next_addr;
                        r_ena   <= 1'b1;
                        r_state <= ST_RD_REQ;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_we    <= 1'b0;
                    r_ena   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bram_addr    = r_addr;
    assign bram_data_in = '0;
    assign bram_we      = r_we;
    assign bram_ena     = r_ena;
    assign sample_data  = r_sample_data;
    assign sample_valid = r_sample_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_pulse_bram_reader.sv
// Scoreboard bench: two readers (clear-on-read on/off) run in lockstep
// against their own single-port BRAM models.
module tb_pulse_bram_reader;

    localparam logic [31:0] PRE [13] = '{
        32'h3D7C5048, 32'h3E99652C, 32'h3E0E3BCD, 32'h3F000000,
        32'h3E4CCCCD, 32'h3DCCCCCD, 32'h3D4CCCCD, 32'h3CA3D70A,
        32'h3C23D70A, 32'h3B83126F, 32'h3A83126F, 32'h3951B717,
        32'h38D1B717
    };

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        sready;
    logic [31:0] sdata  [2];
    logic        svalid [2];
    logic        sbusy  [2];
    logic        sdone  [2];

    logic        load;
    logic [31:0] img  [16];
    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    logic we_seen1 = 1'b0;

    pulse_bram_if bus0 ();
    pulse_bram_if bus1 ();

    pulse_bram_reader #(
        .DEPTH(13), .BASE_ADDR(32'h0), .CLEAR_ON_READ(1'b1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bram_addr(bus0.bram_addr), .bram_data_in(bus0.bram_data_in),
        .bram_we(bus0.bram_we), .bram_ena(bus0.bram_ena),
        .bram_data_out(bus0.bram_data_out),
        .sample_data(sdata[0]), .sample_valid(svalid[0]), .sample_ready(sready),
        .busy(sbusy[0]), .done(sdone[0])
    );

    pulse_bram_reader #(
        .DEPTH(13), .BASE_ADDR(32'h0), .CLEAR_ON_READ(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bram_addr(bus1.bram_addr), .bram_data_in(bus1.bram_data_in),
        .bram_we(bus1.bram_we), .bram_ena(bus1.bram_ena),
        .bram_data_out(bus1.bram_data_out),
        .sample_data(sdata[1]), .sample_valid(svalid[1]), .sample_ready(sready),
        .busy(sbusy[1]), .done(sdone[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first single-port BRAM models with one-clock read latency.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) mem0[i] <= img[i];
        end else if (bus0.bram_ena) begin
            if (bus0.bram_we) mem0[bus0.bram_addr[5:2]] <= bus0.bram_data_in;
            bus0.bram_data_out <= mem0[bus0.bram_addr[5:2]];
        end
    end

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) mem1[i] <= img[i];
        end else if (bus1.bram_ena) begin
            if (bus1.bram_we) mem1[bus1.bram_addr[5:2]] <= bus1.bram_data_in;
            bus1.bram_data_out <= mem1[bus1.bram_addr[5:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: a handshake is due at the next edge whenever valid&&ready is
    // stable at the falling edge and no abort overrides it.
    initial forever begin
        logic [31:0] e;
        @(negedge clk);
        if (rst_n && sready && !abort) begin
            if (svalid[0]) begin
                if (q0.size() == 0) check("unexpected_sample0", 32'(svalid[0]), 32'd0);
                else begin
                    e = q0.pop_front();
                    check("sample0", sdata[0], e);
                end
            end
            if (svalid[1]) begin
                if (q1.size() == 0) check("unexpected_sample1", 32'(svalid[1]), 32'd0);
                else begin
                    e = q1.pop_front();
                    check("sample1", sdata[1], e);
                end
            end
        end
        if (sdone[0]) done_cnt0++;
        if (sdone[1]) done_cnt1++;
        if (bus1.bram_we) we_seen1 = 1'b1;
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr"},    bus0.bram_addr, 32'h0);
        check({tag, "_din"},     bus0.bram_data_in, 32'h0);
        check({tag, "_we"},      32'(bus0.bram_we), 32'h0);
        check({tag, "_ena"},     32'(bus0.bram_ena), 32'h0);
        check({tag, "_sdata"},   sdata[0], 32'h0);
        check({tag, "_svalid"},  32'(svalid[0]), 32'h0);
        check({tag, "_busy"},    32'(sbusy[0]), 32'h0);
        check({tag, "_done"},    32'(sdone[0]), 32'h0);
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) begin
            if (i < 13) img[i] = PRE[i];
            else img[i] = 32'h0;
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic frame(input int stall_w, input int abort_w, input bit restart);
        int dc0;
        int dc1;
        int st;
        int guard;
        preload();
        for (int i = 0; i < 13; i++) begin
            q0.push_back(PRE[i]);
            q1.push_back(PRE[i]);
        end
        dc0 = done_cnt0;
        dc1 = done_cnt1;
        st = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < 13; w++) begin
            guard = 0;
            while (!svalid[0] && guard < 20) begin
                tick();
                guard++;
            end
            check("valid_timeout", 32'(svalid[0]), 32'd1);
            if (w == 0 && stall_w < 0) check("first_valid_latency", 32'(cyc - st), 32'd4);
            if (w == stall_w) begin
                repeat (10) begin
                    check("stall_data", sdata[0], 32'h3E0E3BCD);
                    check("stall_valid", 32'(svalid[0]), 32'd1);
                    check("stall_no_write", 32'(bus0.bram_we), 32'd0);
                    tick();
                end
            end
            if (w == abort_w) begin
                abort = 1'b1;
                sready = 1'b1;
                tick();
                abort = 1'b0;
                sready = 1'b0;
                check("abort_valid", 32'(svalid[0]), 32'd0);
                check("abort_ena", 32'(bus0.bram_ena), 32'd0);
                check("abort_we", 32'(bus0.bram_we), 32'd0);
                check("abort_busy", 32'(sbusy[0]), 32'd0);
                check("abort_left", 32'(q0.size()), 32'(13 - w));
                q0.delete();
                q1.delete();
                repeat (8) tick();
                check("abort_no_done", 32'(done_cnt0 - dc0), 32'd0);
                check("abort_idle_ena", 32'(bus0.bram_ena), 32'd0);
                return;
            end
            if (restart && w == 4) start = 1'b1;
            sready = 1'b1;
            tick();
            sready = 1'b0;
            start = 1'b0;
        end
        guard = 0;
        while (!sdone[0] && guard < 20) begin
            tick();
            guard++;
        end
        check("done_timeout", 32'(sdone[0]), 32'd1);
        if (stall_w < 0) check("done_latency", 32'(cyc - st), 32'd66);
        if (restart) start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("done_count0", 32'(done_cnt0 - dc0), 32'd1);
        check("done_count1", 32'(done_cnt1 - dc1), 32'd1);
        check("idle_busy", 32'(sbusy[0]), 32'd0);
        check("idle_valid", 32'(svalid[0]), 32'd0);
        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);
    endtask

    task automatic check_mems(input int cleared_upto);
        for (int i = 0; i < 13; i++) begin
            if (i < cleared_upto) check("mem0_cleared", mem0[i], 32'h0);
            else check("mem0_intact", mem0[i], PRE[i]);
            check("mem1_intact", mem1[i], PRE[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        sready = 1'b0;
        load   = 1'b0;
        for (int i = 0; i < 16; i++) img[i] = 32'h0;
        tick();
        tick();
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        frame(-1, -1, 1'b0);
        check_mems(13);

        frame(2, -1, 1'b0);
        check_mems(13);

        frame(-1, 5, 1'b0);
        check_mems(5);

        frame(-1, -1, 1'b1);
        check_mems(13);

        // Asynchronous reset while the first read is in RD_WAIT.
        preload();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rdwait_ena", 32'(bus0.bram_ena), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        frame(-1, -1, 1'b0);
        check_mems(13);

        check("cor0_never_writes", 32'(we_seen1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_bram_reader.md
PULSE_BRAM_READER -- requirements
Module: pulse_bram_reader

Interface
REQ-001 Parameter: DEPTH, 13, number of 32-bit pulse-table words per frame.
REQ-002 Parameter: BASE_ADDR, 0, byte address of word 0.
REQ-003 Parameter: CLEAR_ON_READ, 1, when 1 each word is overwritten with 32'h0 after it is delivered.
REQ-004 Ports: clk  in  1  single clock; all logic on posedge.
REQ-005 Ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Ports: start  in  1  frame request, sampled only in IDLE.
REQ-007 Ports: abort  in  1  synchronous frame cancel.
REQ-008 Ports: bram_addr  out  32  byte address, BASE_ADDR + 4*index.
REQ-009 Ports: bram_data_in  out  32  write data; always 32'h0.
REQ-010 Ports: bram_we  out  1  write enable.
REQ-011 Ports: bram_ena  out  1  port enable.
REQ-012 Ports: bram_data_out  in  32  BRAM read data; valid one clock after a read is sampled.
REQ-013 Ports: sample_data  out  32  fp32 pulse sample.
REQ-014 Ports: sample_valid  out  1  sample_data is valid.
REQ-015 Ports: sample_ready  in  1  consumer accepts the sample.
REQ-016 Ports: busy  out  1  high in every state except IDLE.
REQ-017 Ports: done  out  1  one-cycle pulse at frame completion.

Function
REQ-018 All outputs shall be registered, with states IDLE, RD_REQ, RD_WAIT, RD_CAP, OUT, CLR, and DONE.
REQ-019 IDLE: ena=0, we=0; start=1 -> index=0, go to RD_REQ.
REQ-020 RD_REQ: drive bram_addr=BASE_ADDR+4*index, ena=1, we=0 -> RD_WAIT.
REQ-021 RD_WAIT: hold the address and ena -> RD_CAP.
REQ-022 RD_CAP: sample_data<=bram_data_out, sample_valid<=1, ena<=0 -> OUT.
REQ-023 OUT: sample_data and sample_valid shall stay stable until sample_valid&&sample_ready.
REQ-024 OUT, on handshake: sample_valid<=0; if CLEAR_ON_READ, drive addr=same index, we=1, ena=1, data_in=0 -> CLR; otherwise -> CLR with ena=0.
REQ-025 CLR: we<=0, ena<=0; index==DEPTH-1 -> DONE, else index+1 -> RD_REQ.
REQ-026 DONE: done=1 for exactly one cycle -> IDLE.
REQ-027 Latency: sample_valid rises 3 clocks after the edge that samples start in IDLE.
REQ-028 Latency: an unstalled frame shall take 5*DEPTH+1 clocks from start to the done pulse (66 for DEPTH=13).
REQ-029 start while busy (including DONE) shall be ignored, with no queuing.
REQ-030 abort=1 in any non-IDLE state shall go to IDLE next edge with ena=0, we=0, sample_valid=0, and no done pulse.
REQ-031 abort shall not write a word that has not been handshaken; abort has priority over a same-cycle handshake.
REQ-032 index shall be ceil(log2(DEPTH)) bits wide.
REQ-033 Address arithmetic shall be 32-bit unsigned; wrap-around is not required (BASE_ADDR+4*DEPTH < 2^32).
REQ-034 bram_ena shall be asserted only in RD_REQ, RD_WAIT, and the CLR write cycle, so an external arbiter can share the port with the pulse generator.

Reset
REQ-035 rst_n=0 shall immediately force IDLE, index=0, bram_addr=0, bram_data_in=0, bram_we=0, bram_ena=0, sample_data=0, sample_valid=0, busy=0, done=0.
REQ-036 Reset mid-frame shall abandon the frame with no further BRAM access; words already cleared remain cleared.

Structure
REQ-037 Shared package pulse_pkg shall hold PULSE_DEPTH=13, WORD_BYTES=4, and the reader state encoding.
REQ-038 The design shall be a single module with no sub-module; the bench shall reuse the existing single-port bram model.

Verification
REQ-039 Ready stall: BRAM words 0..12 preloaded with 3D7C5048, 3E99652C, 3E0E3BCD ... 38D1B717, ready held 1, start pulse -> 13 samples in address order, done 66 clocks after start, all 13 words read back 0.
REQ-040 Backpressure: ready held 0 for 10 clocks at word 2 -> sample_data=3E0E3BCD is stable, valid is held, and no write to addr 8 occurs until the handshake.
REQ-041 CLEAR_ON_READ=0, same preload -> identical sample stream, BRAM contents unchanged, we never asserted.
REQ-042 abort asserted while in OUT for word 5 -> IDLE next clock, words 0..4 zero, words 5..12 intact, no done pulse.
REQ-043 start pulsed again mid-frame -> ignored, exactly 13 samples and one done pulse.
REQ-044 rst_n driven low asynchronously during RD_WAIT -> all outputs 0 before the next edge, then a new start yields a full correct frame.
